sched_controller: RTL

//  Control FSM driving the scheduled 1-ALU/1-MUL datapath (i1..i8 -> result).

---
 rtl/sched_controller_if.sv | 38 +++
 rtl/sched_controller.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/sched_controller_if.sv
// Control bundle between the schedule controller and the 1-ALU/1-MUL datapath.
// master: controller side (receives start, drives selects/ops/enables).
// slave: datapath / top-level handshake side.
interface sched_controller_if #(
  parameter int SEL_W = 4
);
  logic             start;
  logic             busy;
  logic [SEL_W-1:0] alu1_sel1;
  logic [SEL_W-1:0] alu1_sel2;
  logic             alu1_op;
  logic [SEL_W-1:0] mul1_sel1;
  logic [SEL_W-1:0] mul1_sel2;
  logic             mul1_op;
  logic             reg_mul2_en;
  logic             reg_mul4_en;
  logic             reg_mul6_en;
  logic             reg_mul9_en;
  logic             reg_mul11_en;
  logic             reg_mul13_en;
  logic             reg_alu14_en;
  logic             result_en;
  logic             done_next;

  modport master (
    input  start,
    output busy, alu1_sel1, alu1_sel2, alu1_op, mul1_sel1, mul1_sel2, mul1_op,
           reg_mul2_en, reg_mul4_en, reg_mul6_en, reg_mul9_en, reg_mul11_en,
           reg_mul13_en, reg_alu14_en, result_en, done_next
  );

  modport slave (
    output start,
    input  busy, alu1_sel1, alu1_sel2, alu1_op, mul1_sel1, mul1_sel2, mul1_op,
           reg_mul2_en, reg_mul4_en, reg_mul6_en, reg_mul9_en, reg_mul11_en,
           reg_mul13_en, reg_alu14_en, result_en, done_next
  );
endinterface

// File: rtl/sched_controller.sv
// Schedule controller for the 1-ALU/1-MUL datapath computing
//   result = ((i1*i2)*(i3*i4))*(i5*i6) + i7*i8  (mod 2^32)
// Walks a fixed 8-step schedule per run, with a one-deep queued start so
// back-to-back runs proceed without a bubble.
// Optional feature: define SCHED_CTRL_ABORT_EN to add the abort input, which
// cancels a run in any step before the final one.
module sched_controller #(
  parameter int               SEL_W    = 4,
  parameter logic [SEL_W-1:0] IDLE_SEL = SEL_W'(15)
) (
  input logic clk,
  input logic rst,
`ifdef SCHED_CTRL_ABORT_EN
  input logic abort,
`endif
  sched_controller_if.master bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [2:0] LAST_STEP = 3'd7;

  // Operand select codes shared by the ALU and MUL input muxes.
  localparam logic [SEL_W-1:0] SEL_I1    = SEL_W'(0);
  localparam logic [SEL_W-1:0] SEL_I2    = SEL_W'(1);
  localparam logic [SEL_W-1:0] SEL_I3    = SEL_W'(2);
  localparam logic [SEL_W-1:0] SEL_I4    = SEL_W'(3);
  localparam logic [SEL_W-1:0] SEL_I5    = SEL_W'(4);
  localparam logic [SEL_W-1:0] SEL_I6    = SEL_W'(5);
  localparam logic [SEL_W-1:0] SEL_I7    = SEL_W'(6);
  localparam logic [SEL_W-1:0] SEL_I8    = SEL_W'(7);
  localparam logic [SEL_W-1:0] SEL_MUL2  = SEL_W'(8);
  localparam logic [SEL_W-1:0] SEL_MUL4  = SEL_W'(9);
  localparam logic [SEL_W-1:0] SEL_MUL6  = SEL_W'(10);
  localparam logic [SEL_W-1:0] SEL_MUL9  = SEL_W'(11);
  localparam logic [SEL_W-1:0] SEL_MUL11 = SEL_W'(12);
  localparam logic [SEL_W-1:0] SEL_MUL13 = SEL_W'(13);

  logic [0:0] state;
  logic [2:0] step;
  logic       pending;
  logic       abort_req;

  // Abort is honoured only before the last step; by S7 the result load is already issued.
`ifdef SCHED_CTRL_ABORT_EN
  assign abort_req = abort && (state == ST_RUN) && (step != LAST_STEP);
`else
  assign abort_req = 1'b0;
`endif

  // Sequencer: start/queue handling, step advance and rerun-or-idle decision after S7.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      step    <= 3'd0;
      pending <= 1'b0;
    end else if (abort_req) begin
      state   <= ST_IDLE;
      step    <= 3'd0;
      pending <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          step    <= 3'd0;
          pending <= 1'b0;
          if (bus.start) state <= ST_RUN;
        end
        ST_RUN: begin
          if (step == LAST_STEP) begin
            step    <= 3'd0;
            pending <= 1'b0;
            if (!(pending || bus.start)) state <= ST_IDLE;
          end else begin
            step <= step + 3'd1;
            if (bus.start) pending <= 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          step    <= 3'd0;
          pending <= 1'b0;
        end
      endcase
    end
  end

  // Output decode: idle values by default, one schedule row per active step.
  always_comb begin
    bus.busy         = 1'b0;
    bus.alu1_sel1    = IDLE_SEL;
    bus.alu1_sel2    = IDLE_SEL;
    bus.alu1_op      = 1'b0;
    bus.mul1_sel1    = IDLE_SEL;
    bus.mul1_sel2    = IDLE_SEL;
    bus.mul1_op      = 1'b0;
    bus.reg_mul2_en  = 1'b0;
    bus.reg_mul4_en  = 1'b0;
    bus.reg_mul6_en  = 1'b0;
    bus.reg_mul9_en  = 1'b0;
    bus.reg_mul11_en = 1'b0;
    bus.reg_mul13_en = 1'b0;
    bus.reg_alu14_en = 1'b0;
    bus.result_en    = 1'b0;
    bus.done_next    = 1'b0;
    if (state == ST_RUN) begin
      bus.busy = 1'b1;
      case (step)
        3'd0: begin
          bus.mul1_sel1   = SEL_I1;
          bus.mul1_sel2   = SEL_I2;
          bus.reg_mul2_en = 1'b1;
        end
        3'd1: begin
          bus.mul1_sel1   = SEL_I3;
          bus.mul1_sel2   = SEL_I4;
          bus.reg_mul4_en = 1'b1;
        end
        3'd2: begin
          bus.mul1_sel1   = SEL_I5;
          bus.mul1_sel2   = SEL_I6;
          bus.reg_mul6_en = 1'b1;
        end
        3'd3: begin
          bus.mul1_sel1   = SEL_MUL2;
          bus.mul1_sel2   = SEL_MUL4;
          bus.reg_mul9_en = 1'b1;
        end
        3'd4: begin
          bus.mul1_sel1    = SEL_I7;
          bus.mul1_sel2    = SEL_I8;
          bus.reg_mul11_en = 1'b1;
        end
        3'd5: begin
          bus.mul1_sel1    = SEL_MUL9;
          bus.mul1_sel2    = SEL_MUL6;
          bus.reg_mul13_en = 1'b1;
        end
        3'd6: begin
          bus.alu1_sel1    = SEL_MUL13;
          bus.alu1_sel2    = SEL_MUL11;
          bus.reg_alu14_en = 1'b1;
        end
        default: begin
          bus.result_en = 1'b1;
          bus.done_next = 1'b1;
        end
      endcase
    end
  end

endmodule
